// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared register-file geometry and the write-back entry type used by the
// write-back arbiter and its load-result buffer.
package regfile_writeback_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // r0 is hard-wired to zero, so nothing may ever be written to it.
  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    logic      valid;
    reg_idx_t  dest;
    reg_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Handshake bundle between the ALU / load unit, the write-back arbiter and
// the register-file write port.
interface regfile_writeback_arbiter_if;
  import regfile_writeback_arbiter_pkg::*;

  logic                alu_valid;
  reg_idx_t            alu_dest;
  reg_data_t           alu_data;
  logic                alu_stall;

  logic                mem_valid;
  logic                mem_ready;
  reg_idx_t            mem_dest;
  reg_data_t           mem_data;

  logic                reg_write_en;
  reg_idx_t            reg_write_dest;
  reg_data_t           reg_write_data;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  alu_stall, mem_ready,
    input  reg_write_en, reg_write_dest, reg_write_data, pending
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output alu_stall, mem_ready,
    output reg_write_en, reg_write_dest, reg_write_data, pending
  );

endinterface

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Load-result circular buffer: entries carry a valid bit that a newer ALU
// write can clear by destination; valid entries form the pending mask.
module wb_result_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  wb_entry_t           push_entry,
  input  logic                pop,
  input  logic                kill_en,
  input  reg_idx_t            kill_dest,
  output logic                head_present,
  output wb_entry_t           head_entry,
  output logic                full,
  output logic [NUM_REGS-1:0] pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [FIFO_DEPTH-1:0] occ_q;
  logic [FIFO_DEPTH-1:0] valid_q;
  reg_idx_t              dest_q [FIFO_DEPTH];
  reg_data_t             data_q [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
      valid_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (kill_en && occ_q[i] && dest_q[i] == kill_dest) valid_q[i] <= 1'b0;
      end
      if (pop) begin
        occ_q[rd_ptr_q]   <= 1'b0;
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      // A push lands on a free slot; its own valid bit overrides any kill above.
      if (push) begin
        occ_q[wr_ptr_q]   <= 1'b1;
        valid_q[wr_ptr_q] <= push_entry.valid;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: payload storage has no reset; occ_q/valid_q alone decide whether a
  // slot means anything, so clearing dest/data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= push_entry.dest;
      data_q[wr_ptr_q] <= push_entry.data;
    end
  end

  assign head_present     = occ_q[rd_ptr_q];
  assign head_entry.valid = valid_q[rd_ptr_q];
  assign head_entry.dest  = dest_q[rd_ptr_q];
  assign head_entry.data  = data_q[rd_ptr_q];
  assign full             = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) pending[dest_q[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Sole writer of the register-file port: ALU results win the slot, queued
// loads drain behind them, and an age limit forces the oldest load through.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input logic                        clk,
  input logic                        rst,
  regfile_writeback_arbiter_if.slave wb
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;

  logic      alu_accept, mem_accept;
  logic      push, pop;
  wb_entry_t push_entry;
  logic      head_present, head_live;
  wb_entry_t head_entry;
  logic      fifo_full;

  logic      sel_en;
  reg_idx_t  sel_dest;
  reg_data_t sel_data;

  logic      wr_en_q;
  reg_idx_t  wr_dest_q;
  reg_data_t wr_data_q;

  assign wb.alu_stall = (state_q == ST_FORCE);
  assign wb.mem_ready = ~fifo_full & ~rst;

  assign alu_accept = wb.alu_valid & ~wb.alu_stall;
  assign mem_accept = wb.mem_valid & wb.mem_ready;

  // A load racing an ALU write to the same register is already stale.
  assign push             = mem_accept && (wb.mem_dest != REG_ZERO);
  assign push_entry.valid = !(alu_accept && (wb.alu_dest == wb.mem_dest));
  assign push_entry.dest  = wb.mem_dest;
  assign push_entry.data  = wb.mem_data;

  assign head_live = head_present & head_entry.valid;
  assign pop       = head_present & (~head_entry.valid | ~alu_accept);

  wb_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .kill_en      (alu_accept),
    .kill_dest    (wb.alu_dest),
    .head_present (head_present),
    .head_entry   (head_entry),
    .full         (fifo_full),
    .pending      (wb.pending)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs can leave a value unassigned and infer a latch.
  always_comb begin
    sel_en   = 1'b0;
    sel_dest = REG_ZERO;
    sel_data = '0;
    if (alu_accept) begin
      if (wb.alu_dest != REG_ZERO) begin
        sel_en   = 1'b1;
        sel_dest = wb.alu_dest;
        sel_data = wb.alu_data;
      end
    end else if (head_live) begin
      sel_en   = 1'b1;
      sel_dest = head_entry.dest;
      sel_data = head_entry.data;
    end
  end

  always_comb begin
    age_d = age_q;
    if (pop) begin
      age_d = '0;
    end else if (head_live && age_q != AGE_W'(MAX_WAIT)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (head_live && !pop && age_q == AGE_W'(MAX_WAIT)) state_d = ST_FORCE;
      ST_FORCE:  if (pop) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      age_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= REG_ZERO;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      wr_en_q   <= sel_en;
      wr_dest_q <= sel_dest;
      wr_data_q <= sel_data;
    end
  end

  assign wb.reg_write_en   = wr_en_q;
  assign wb.reg_write_dest = wr_dest_q;
  assign wb.reg_write_data = wr_data_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for the write-back arbiter: ALU writes, load latency, age-forced
// drain, WAW kill, FIFO back-pressure, r0 handling and async reset.
module tb_regfile_writeback_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  regfile_writeback_arbiter_if wb ();

  regfile_writeback_arbiter #(
    .FIFO_DEPTH (2),
    .MAX_WAIT   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [2:0] dest,
                          input logic [15:0] data);
    check({tag, ".en"},   32'(wb.reg_write_en),   32'(en));
    check({tag, ".dest"}, 32'(wb.reg_write_dest), 32'(dest));
    check({tag, ".data"}, 32'(wb.reg_write_data), 32'(data));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    wb.alu_valid = 1'b0; wb.alu_dest = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_dest = '0; wb.mem_data = '0;
    settle();
    check_wr("reset", 1'b0, 3'd0, 16'h0000);
    check("reset.stall",     32'(wb.alu_stall), 32'd0);
    check("reset.pending",   32'(wb.pending),   32'd0);
    check("reset.mem_ready", 32'(wb.mem_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    settle();
    check("release.mem_ready", 32'(wb.mem_ready), 32'd1);

    // 1: single ALU write, one-cycle latency
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd3; wb.alu_data = 16'h1234;
    settle();
    check("t1.stall", 32'(wb.alu_stall), 32'd0);
    tick();
    wb.alu_valid = 1'b0;
    check_wr("t1.wr", 1'b1, 3'd3, 16'h1234);
    tick();
    check_wr("t1.idle", 1'b0, 3'd0, 16'h0000);

    // 2: single load, two-cycle latency, pending for one cycle
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd5; wb.mem_data = 16'hBEEF;
    tick();
    wb.mem_valid = 1'b0;
    check("t2.pending", 32'(wb.pending), 32'h20);
    check_wr("t2.none", 1'b0, 3'd0, 16'h0000);
    tick();
    check_wr("t2.wr", 1'b1, 3'd5, 16'hBEEF);
    check("t2.pending_clr", 32'(wb.pending), 32'h00);

    // 3: continuous ALU stream starves a load until the age limit forces it
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd1; wb.alu_data = 16'h0100;
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd4; wb.mem_data = 16'hAAAA;
    tick();
    wb.mem_valid = 1'b0;
    check("t3.pending", 32'(wb.pending), 32'h10);
    for (int i = 1; i <= 5; i++) begin
      check("t3.no_stall", 32'(wb.alu_stall), 32'd0);
      check_wr("t3.alu", 1'b1, 3'd1, 16'(32'h0100 + i - 1));
      wb.alu_data = 16'(32'h0100 + i);
      tick();
    end
    check("t3.stall", 32'(wb.alu_stall), 32'd1);
    check_wr("t3.alu5", 1'b1, 3'd1, 16'h0105);
    wb.alu_data = 16'h0106;
    tick();
    check("t3.stall_clr", 32'(wb.alu_stall), 32'd0);
    check_wr("t3.load", 1'b1, 3'd4, 16'hAAAA);
    check("t3.pending_clr", 32'(wb.pending), 32'h00);
    tick();
    wb.alu_valid = 1'b0;
    check_wr("t3.held", 1'b1, 3'd1, 16'h0106);
    tick();
    check_wr("t3.idle", 1'b0, 3'd0, 16'h0000);

    // 4: WAW kill of a queued load by a newer ALU result
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd2; wb.mem_data = 16'h5555;
    tick();
    wb.mem_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd2; wb.alu_data = 16'h0007;
    check("t4.pending", 32'(wb.pending), 32'h04);
    tick();
    wb.alu_valid = 1'b0;
    check_wr("t4.alu", 1'b1, 3'd2, 16'h0007);
    check("t4.pending_kill", 32'(wb.pending), 32'h00);
    tick();
    check_wr("t4.no_stale", 1'b0, 3'd0, 16'h0000);

    // 5: two loads fill the FIFO behind ALU traffic; third load waits one pop
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd6; wb.alu_data = 16'h0600;
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd3; wb.mem_data = 16'h3333;
    tick();
    wb.alu_data = 16'h0601;
    wb.mem_dest = 3'd5; wb.mem_data = 16'h5A5A;
    settle();
    check("t5.ready1", 32'(wb.mem_ready), 32'd1);
    check_wr("t5.alu0", 1'b1, 3'd6, 16'h0600);
    tick();
    wb.alu_valid = 1'b0;
    wb.mem_dest = 3'd7; wb.mem_data = 16'h7777;
    settle();
    check("t5.full", 32'(wb.mem_ready), 32'd0);
    check("t5.pending", 32'(wb.pending), 32'h28);
    check_wr("t5.alu1", 1'b1, 3'd6, 16'h0601);
    tick();
    check("t5.ready_after_pop", 32'(wb.mem_ready), 32'd1);
    check_wr("t5.load3", 1'b1, 3'd3, 16'h3333);
    check("t5.pending2", 32'(wb.pending), 32'h20);
    tick();
    wb.mem_valid = 1'b0;
    check_wr("t5.load5", 1'b1, 3'd5, 16'h5A5A);
    check("t5.pending3", 32'(wb.pending), 32'h80);
    tick();
    check_wr("t5.load7", 1'b1, 3'd7, 16'h7777);
    check("t5.pending_clr", 32'(wb.pending), 32'h00);
    tick();
    check_wr("t5.idle", 1'b0, 3'd0, 16'h0000);

    // 6: r0 destinations are accepted but never written or queued
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd0; wb.alu_data = 16'hDEAD;
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd0; wb.mem_data = 16'hBEEF;
    settle();
    check("t6.ready", 32'(wb.mem_ready), 32'd1);
    tick();
    wb.alu_valid = 1'b0; wb.mem_valid = 1'b0;
    check_wr("t6.no_alu", 1'b0, 3'd0, 16'h0000);
    check("t6.pending", 32'(wb.pending), 32'h00);
    tick();
    check_wr("t6.no_load", 1'b0, 3'd0, 16'h0000);

    // 7: async reset with a full FIFO and a write in flight
    wb.alu_valid = 1'b1; wb.alu_dest = 3'd1; wb.alu_data = 16'h1111;
    wb.mem_valid = 1'b1; wb.mem_dest = 3'd2; wb.mem_data = 16'h2222;
    tick();
    wb.alu_data = 16'h1112;
    wb.mem_dest = 3'd3; wb.mem_data = 16'h3333;
    tick();
    wb.mem_valid = 1'b0;
    wb.alu_data = 16'h1113;
    settle();
    check("t7.full", 32'(wb.mem_ready), 32'd0);
    check("t7.pending", 32'(wb.pending), 32'h0C);
    check_wr("t7.inflight", 1'b1, 3'd1, 16'h1112);
    #2;
    rst = 1'b1;
    #1;
    check_wr("t7.rst", 1'b0, 3'd0, 16'h0000);
    check("t7.rst.stall",     32'(wb.alu_stall), 32'd0);
    check("t7.rst.pending",   32'(wb.pending),   32'd0);
    check("t7.rst.mem_ready", 32'(wb.mem_ready), 32'd0);
    wb.alu_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("t7.release.ready", 32'(wb.mem_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wr("t7.after", 1'b0, 3'd0, 16'h0000);
      check("t7.after.pending", 32'(wb.pending), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
